// File: rtl/ask_pkg.sv
// Shared definitions for the ASK receive path and the transmit-side PRBS7 generator.
package ask_pkg;
    localparam int          SAMPLE_W = 12;
    localparam logic [11:0] MIDSCALE = 12'd2048;

    // Samples per bit, indexed by bit_rate_sel.
    localparam logic [12:0] BIT_PERIOD [0:3] = '{13'd4096, 13'd2048, 13'd1024, 13'd512};

    // PRBS7, x^7 + x^6 + 1: feedback from register bits 6 and 5.
    localparam int PRBS7_LEN        = 7;
    localparam int PRBS7_TAP_HI     = 6;
    localparam int PRBS7_TAP_LO     = 5;
    localparam int PRBS_SYNC_HITS   = 16;
    localparam int PRBS_DROP_MISSES = 4;

    typedef enum logic {HUNT = 1'b0, TRACK = 1'b1} ask_state_t;

    function automatic logic prbs7_bit(input logic [PRBS7_LEN-1:0] r);
        return r[PRBS7_TAP_HI] ^ r[PRBS7_TAP_LO];
    endfunction
endpackage

// File: rtl/ask_envelope_detector.sv
// Rectifier and windowed peak hold; envelope and level decision refresh once per window.
module ask_envelope_detector
    import ask_pkg::*;
#(
    parameter int ENV_WIN = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] threshold,
    output logic [SAMPLE_W-1:0] envelope,
    output logic                env_level
);
    localparam int             WIN_W    = (ENV_WIN > 1) ? $clog2(ENV_WIN) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(ENV_WIN - 1);

    logic [WIN_W-1:0]    win_cnt;
    logic [SAMPLE_W-1:0] rect, run_max, win_peak;

    // Full-scale negative (code 0) rectifies to 2048, which still fits in 12 bits.
    assign rect     = (sample_in >= MIDSCALE) ? (sample_in - MIDSCALE) : (MIDSCALE - sample_in);
    assign win_peak = (rect > run_max) ? rect : run_max;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_cnt   <= '0;
            run_max   <= '0;
            envelope  <= '0;
            env_level <= 1'b0;
        end else if (sample_valid) begin
            if (win_cnt == WIN_LAST) begin
                envelope  <= win_peak;
                env_level <= (win_peak >= threshold);
                run_max   <= '0;
                win_cnt   <= '0;
            end else begin
                run_max <= win_peak;
                win_cnt <= win_cnt + WIN_W'(1);
            end
        end
    end
endmodule

// File: rtl/ask_demodulator.sv
// ASK demodulator: envelope detection, bit timing recovery (HUNT/TRACK) and an
// optional PRBS7 checker enabled by the ASK_DEMOD_PRBS_CHECK_EN macro.
module ask_demodulator
    import ask_pkg::*;
#(
    parameter int ENV_WIN   = 64,
    parameter int LOSS_BITS = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    input  logic [1:0]          bit_rate_sel,
    input  logic [SAMPLE_W-1:0] threshold,
    output logic [SAMPLE_W-1:0] envelope,
    output logic                env_level,
    output logic                bit_out,
    output logic                bit_valid,
    output logic                locked,
    output logic [15:0]         err_count,
    output logic                prbs_sync
);
    localparam int LOSS_W = $clog2(LOSS_BITS + 1);

    ask_state_t        state, state_next;
    logic [11:0]       bit_cnt, bit_cnt_next;
    logic [LOSS_W-1:0] loss_cnt, loss_cnt_next;
    logic [1:0]        sel_prev;
    logic [12:0]       period;
    logic              env_prev, trans, sel_chg, mid_bit, wrap, strobe;

    ask_envelope_detector #(.ENV_WIN(ENV_WIN)) u_env (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .threshold    (threshold),
        .envelope     (envelope),
        .env_level    (env_level)
    );

    assign period  = BIT_PERIOD[bit_rate_sel];
    assign trans   = (env_level != env_prev);
    assign sel_chg = (bit_rate_sel != sel_prev);
    assign mid_bit = ({1'b0, bit_cnt} == (period >> 1) - 13'd1);
    assign wrap    = ({1'b0, bit_cnt} == period - 13'd1);
    assign locked  = (state == TRACK);

    // A rate change outranks everything; a level transition outranks the mid-bit strobe.
    always_comb begin
        state_next    = state;
        bit_cnt_next  = bit_cnt;
        loss_cnt_next = loss_cnt;
        strobe        = 1'b0;
        if (sel_chg) begin
            state_next    = HUNT;
            bit_cnt_next  = '0;
            loss_cnt_next = '0;
        end else begin
            case (state)
                HUNT: begin
                    if (trans) begin
                        state_next    = TRACK;
                        bit_cnt_next  = '0;
                        loss_cnt_next = '0;
                    end
                end
                TRACK: begin
                    if (trans) begin
                        bit_cnt_next  = '0;
                        loss_cnt_next = '0;
                    end else if (sample_valid) begin
                        strobe = mid_bit;
                        if (wrap) begin
                            bit_cnt_next = '0;
                            if (loss_cnt == LOSS_W'(LOSS_BITS - 1)) begin
                                state_next    = HUNT;
                                loss_cnt_next = '0;
                            end else begin
                                loss_cnt_next = loss_cnt + LOSS_W'(1);
                            end
                        end else begin
                            bit_cnt_next = bit_cnt + 12'd1;
                        end
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= HUNT;
            bit_cnt   <= '0;
            loss_cnt  <= '0;
            env_prev  <= 1'b0;
            sel_prev  <= '0;
            bit_valid <= 1'b0;
            bit_out   <= 1'b0;
        end else begin
            state     <= state_next;
            bit_cnt   <= bit_cnt_next;
            loss_cnt  <= loss_cnt_next;
            env_prev  <= env_level;
            sel_prev  <= bit_rate_sel;
            bit_valid <= strobe;
            if (strobe) bit_out <= env_level;
        end
    end

`ifdef ASK_DEMOD_PRBS_CHECK_EN
    logic                 hunt_to_track, prbs_match;
    logic [PRBS7_LEN-1:0] prbs_reg;
    logic [2:0]           prbs_fill, miss_run;
    logic [4:0]           match_run;

    assign hunt_to_track = (state == HUNT) && (state_next == TRACK);
    assign prbs_match    = (bit_out == prbs7_bit(prbs_reg));

    // Checks the registered strobe, so counters settle one cycle after bit_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prbs_reg  <= '0;
            prbs_fill <= '0;
            match_run <= '0;
            miss_run  <= '0;
            prbs_sync <= 1'b0;
            err_count <= '0;
        end else begin
            if (bit_valid) begin
                prbs_reg <= {prbs_reg[PRBS7_LEN-2:0], bit_out};
                if (prbs_fill != 3'(PRBS7_LEN)) begin
                    prbs_fill <= prbs_fill + 3'd1;
                end else if (prbs_match) begin
                    miss_run <= '0;
                    if (match_run != 5'(PRBS_SYNC_HITS)) match_run <= match_run + 5'd1;
                    if (match_run >= 5'(PRBS_SYNC_HITS - 1)) prbs_sync <= 1'b1;
                end else begin
                    match_run <= '0;
                    if (miss_run != 3'(PRBS_DROP_MISSES)) miss_run <= miss_run + 3'd1;
                    if (miss_run >= 3'(PRBS_DROP_MISSES - 1)) prbs_sync <= 1'b0;
                    if (prbs_sync && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
                end
            end
            if (hunt_to_track) err_count <= '0;
        end
    end
`else
    assign err_count = 16'd0;
    assign prbs_sync = 1'b0;
`endif
endmodule

// File: tb/tb_ask_demodulator.sv
// Bench for ask_demodulator: sample-level behavioural model checked every cycle,
// plus directed keyed-carrier scenarios with hand-computed sample indices.
module tb_ask_demodulator;
`ifdef ASK_DEMOD_PRBS_CHECK_EN
    localparam bit PRBS_ON = 1'b1;
`else
    localparam bit PRBS_ON = 1'b0;
`endif
    localparam int          WIN    = 64;
    localparam int          LOSS   = 32;
    localparam logic [11:0] AMP_HI = 12'd1800;
    localparam logic [11:0] AMP_LO = 12'd100;

    logic        clk = 1'b0, reset = 1'b1;
    logic [11:0] sample_in = 12'd2048, threshold = 12'd900;
    logic        sample_valid = 1'b0;
    logic [1:0]  bit_rate_sel = 2'b11;
    logic [11:0] envelope;
    logic        env_level, bit_out, bit_valid, locked, prbs_sync;
    logic [15:0] err_count;

    always #10 clk = ~clk;

    ask_demodulator #(.ENV_WIN(WIN), .LOSS_BITS(LOSS)) dut (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .bit_rate_sel(bit_rate_sel), .threshold(threshold), .envelope(envelope),
        .env_level(env_level), .bit_out(bit_out), .bit_valid(bit_valid), .locked(locked),
        .err_count(err_count), .prbs_sync(prbs_sync)
    );

    int n_vec = 0, n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Model: window of rectified values, valid samples since the last realignment,
    // and a history of recovered bits for the PRBS rule.
    int       m_win[$];
    int       m_env, m_since, m_err, m_match, m_miss;
    bit       m_lvl, m_lvl_prev, m_track, m_bv, m_bo, m_sync;
    bit [1:0] m_sel_prev;
    bit       m_hist[$];

    always @(posedge clk) begin : model
        int p, mx, r;
        bit trans, stb, pred;
        if (reset) begin
            m_win.delete(); m_hist.delete();
            m_env = 0; m_since = 0; m_err = 0; m_match = 0; m_miss = 0;
            m_lvl = 0; m_lvl_prev = 0; m_track = 0; m_bv = 0; m_bo = 0; m_sync = 0;
            m_sel_prev = 2'b00;
        end else begin
            if (PRBS_ON && m_bv) begin
                if (m_hist.size() >= 7) begin
                    pred = m_hist[m_hist.size()-7] ^ m_hist[m_hist.size()-6];
                    if (m_bo == pred) begin
                        m_miss = 0; m_match++;
                        if (m_match >= 16) m_sync = 1;
                    end else begin
                        if (m_sync && m_err < 65535) m_err++;
                        m_match = 0; m_miss++;
                        if (m_miss >= 4) m_sync = 0;
                    end
                end
                m_hist.push_back(m_bo);
            end
            p     = 4096 >> bit_rate_sel;
            trans = (m_lvl != m_lvl_prev);
            stb   = 0;
            if (bit_rate_sel != m_sel_prev) begin
                m_track = 0; m_since = 0;
            end else if (trans) begin
                if (!m_track && PRBS_ON) m_err = 0;
                m_track = 1; m_since = 0;
            end else if (m_track && sample_valid) begin
                if (m_since % p == p / 2 - 1) begin stb = 1; m_bo = m_lvl; end
                if (m_since == LOSS * p - 1) begin m_track = 0; m_since = 0; end
                else m_since++;
            end
            m_bv       = stb;
            m_lvl_prev = m_lvl;
            m_sel_prev = bit_rate_sel;
            if (sample_valid) begin
                r = int'(sample_in) - 2048;
                m_win.push_back(r < 0 ? -r : r);
                if (m_win.size() == WIN) begin
                    mx = 0;
                    foreach (m_win[i]) if (m_win[i] > mx) mx = m_win[i];
                    m_env = mx;
                    m_lvl = (mx >= int'(threshold));
                    m_win.delete();
                end
            end
        end
        #1;
        chk("envelope", envelope, m_env);
        chk("env_level", env_level, m_lvl);
        chk("bit_valid", bit_valid, m_bv);
        chk("bit_out", bit_out, m_bo);
        chk("locked", locked, m_track);
        chk("err_count", err_count, m_err);
        chk("prbs_sync", prbs_sync, m_sync);
    end

    // Stimulus bookkeeping, indexed by valid-sample number since reset release.
    int sidx, drop_idx;
    int sb_idx[$], rise_idx[$];
    bit sb_bit[$];
    bit gaps, prev_locked;

    task automatic clear_log();
        sidx = 0; drop_idx = -1; gaps = 0; prev_locked = 0;
        sb_idx.delete(); sb_bit.delete(); rise_idx.delete();
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1; sample_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        clear_log();
    endtask

    // Square carrier at period 2; invalid gap cycles carry code 0 to show they are ignored.
    task automatic feed(input logic [11:0] amp);
        if (gaps && (sidx % 3 == 0)) begin
            @(negedge clk); sample_valid = 1'b0; sample_in = 12'd0;
        end
        @(negedge clk);
        sample_valid = 1'b1;
        sample_in    = sidx[0] ? (12'd2048 - amp) : (12'd2048 + amp);
        @(posedge clk); #2;
        if (bit_valid) begin sb_idx.push_back(sidx); sb_bit.push_back(bit_out); end
        if (locked && !prev_locked) rise_idx.push_back(sidx);
        if (!locked && prev_locked) drop_idx = sidx;
        prev_locked = locked;
        sidx++;
    endtask

    task automatic feed_key(input bit lvl, input int cnt);
        repeat (cnt) feed(lvl ? AMP_HI : AMP_LO);
    endtask

    initial begin
        bit       exp_b [5];
        bit       tx [1:45];
        bit [6:0] s;
        bit       b;
        int       nbad;
        exp_b = '{1, 0, 1, 1, 0};

        // Idle carrier at mid-scale: nothing detected, nothing locks.
        bit_rate_sel = 2'b11; threshold = 12'd512;
        do_reset();
        gaps = 1;
        repeat (1200) feed(12'd0);
        chk("idle_envelope", envelope, 0);
        chk("idle_level", env_level, 0);
        chk("idle_locked", locked, 0);
        chk("idle_strobes", sb_idx.size(), 0);

        // Keyed 1,0,1,1,0 at 512 samples/bit.
        threshold = 12'd900;
        do_reset();
        feed_key(1, 512);
        chk("key_env_hi", envelope, 1800);
        feed_key(0, 512);
        chk("key_env_lo", envelope, 100);
        chk("key_level_lo", env_level, 0);
        feed_key(1, 1024);
        feed_key(0, 512);
        chk("key_lock_idx", q_at(rise_idx, 0), 64);
        chk("key_strobes", sb_idx.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk("key_bit", (i < sb_bit.size()) ? int'(sb_bit[i]) : -1, int'(exp_b[i]));
            chk("key_strobe_idx", q_at(sb_idx, i), 320 + 512 * i);
        end

        // Rate change exactly at a due strobe, then relock at 1024 samples/bit.
        do_reset();
        feed_key(1, 320);
        bit_rate_sel = 2'b10;
        feed_key(1, 1);
        chk("rate_chg_locked", locked, 0);
        chk("rate_chg_strobe", bit_valid, 0);
        feed_key(1, 703);
        feed_key(0, 176);
        gaps = 1;
        feed_key(0, 1500);
        chk("relock_idx", q_at(rise_idx, 1), 1088);
        chk("relock_strobes", sb_idx.size(), 2);
        chk("relock_first", q_at(sb_idx, 0), 1600);
        chk("relock_spacing", q_at(sb_idx, 1) - q_at(sb_idx, 0), 1024);

        // Constant high after lock: lock drops after 32 silent periods.
        bit_rate_sel = 2'b11;
        do_reset();
        feed_key(1, 33 * 512);
        chk("loss_drop_idx", drop_idx, 16448);
        chk("loss_strobes", sb_idx.size(), 32);
        chk("loss_gap", drop_idx - q_at(sb_idx, 31), 256);

        // Reset mid-bit after a strobe of 1.
        do_reset();
        feed_key(1, 400);
        chk("pre_reset_bit", q_at(sb_idx, 0), 320);
        @(negedge clk); reset = 1'b1; sample_valid = 1'b0;
        @(posedge clk); #2;
        chk("rst_envelope", envelope, 0);
        chk("rst_level", env_level, 0);
        chk("rst_bit_out", bit_out, 0);
        chk("rst_bit_valid", bit_valid, 0);
        chk("rst_locked", locked, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        clear_log();
        feed_key(1, 400);
        chk("post_rst_lock", q_at(rise_idx, 0), 64);
        chk("post_rst_strobe", q_at(sb_idx, 0), 320);

        // PRBS7 keyed stream with bit 40 inverted.
        do_reset();
        s = 7'b0100000;
        for (int k = 1; k <= 45; k++) begin
            b = s[6] ^ s[5];
            s = {s[5:0], b};
            tx[k] = (k == 40) ? !b : b;
            feed_key(tx[k], 512);
            if (k == 22) chk("prbs_sync_b22", prbs_sync, 0);
            if (k == 23) chk("prbs_sync_b23", prbs_sync, PRBS_ON ? 1 : 0);
            if (k == 39) chk("prbs_err_b39", err_count, 0);
            if (k == 40) chk("prbs_err_b40", err_count, PRBS_ON ? 1 : 0);
        end
        chk("prbs_strobes", sb_idx.size(), 45);
        nbad = 0;
        for (int k = 1; k <= 45; k++)
            if (k > sb_bit.size() || sb_bit[k-1] != tx[k]) nbad++;
        chk("prbs_bits", nbad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ask_demodulator.md
ASK_DEMODULATOR -- requirements
Module: ask_demodulator

Interface
REQ-001 Parameter ENV_WIN, default 64: samples per envelope window; must be at least one carrier period.
REQ-002 Parameter LOSS_BITS, default 32: bit periods without a level transition before lock is dropped.
REQ-003 clk  in  1  system clock, 50 MHz.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 sample_in  in  12  ASK sample; unsigned offset-binary, mid-scale 2048.
REQ-006 sample_valid  in  1  qualifies sample_in; all counters advance only on valid samples.
REQ-007 bit_rate_sel  in  2  selects samples-per-bit from the package table.
REQ-008 threshold  in  12  envelope decision threshold.
REQ-009 envelope  out  12  last completed window peak of the rectified signal.
REQ-010 env_level  out  1  level decision, envelope >= threshold.
REQ-011 bit_out  out  1  recovered data bit.
REQ-012 bit_valid  out  1  one-cycle strobe qualifying bit_out.
REQ-013 locked  out  1  timing recovery is in TRACK.
REQ-014 err_count  out  16  PRBS bit-error count (see Configuration).
REQ-015 prbs_sync  out  1  PRBS checker is aligned (see Configuration).

Function
REQ-016 Rectify: rect = |sample_in - 2048|, computed 12 bits wide; 0 maps to 2048.
REQ-017 Peak hold: the window maximum is tracked over ENV_WIN valid samples. On the last sample, envelope <= max(running max, rect) and the running max clears.
REQ-018 envelope and env_level update in the cycle after the last sample of a window, which is 1-cycle latency.
REQ-019 env_level updates only at window end; threshold changes take effect at the next window end.
REQ-020 Bit period P = BIT_PERIOD[bit_rate_sel], in valid samples: 00->4096, 01->2048, 10->1024, 11->512.
REQ-021 States are HUNT and TRACK. Reset enters HUNT. HUNT->TRACK on the first env_level transition. TRACK->HUNT after LOSS_BITS consecutive periods without a transition.
REQ-022 In TRACK, bit_cnt counts valid samples 0..P-1 and wraps to 0.
REQ-023 Any env_level transition loads bit_cnt <= 0, which realigns the bit phase.
REQ-024 When bit_cnt == P/2-1: bit_out <= env_level, bit_valid pulses for 1 cycle.
REQ-025 If a transition and the mid-bit point coincide, the transition wins: realign and emit no strobe.
REQ-026 In HUNT, bit_valid stays 0 and bit_cnt holds 0.
REQ-027 A bit_rate_sel change in any state forces HUNT, clears bit_cnt and the no-transition counter, and suppresses bit_valid that cycle.
REQ-028 locked = 1 exactly while in TRACK.

Reset
REQ-029 Reset forces state HUNT.
REQ-030 Reset clears to 0: envelope, env_level, bit_out, bit_valid, locked, err_count, prbs_sync, all counters and the running max.
REQ-031 Reset asserted mid-window or mid-bit discards partial state; no strobe is emitted on release.

Configuration
REQ-032 Macro ASK_DEMOD_PRBS_CHECK_EN.
REQ-033 With the macro defined, a PRBS7 checker (x^7+x^6+1, matching the transmit generator) consumes each bit_valid bit:
- 7-bit shift register; predicted bit = r[6]^r[5], valid once 7 bits are loaded.
- A mismatch while prbs_sync = 1 increments err_count, saturating at 0xFFFF.
- prbs_sync sets after 16 consecutive matches and clears after 4 consecutive mismatches.
- err_count clears on a HUNT->TRACK entry.
REQ-034 Without the macro: err_count = 0 and prbs_sync = 0 constantly, and no checker logic is synthesized.

Structure
REQ-035 Shared package ask_pkg holds:
- SAMPLE_W = 12 and MIDSCALE = 2048.
- The BIT_PERIOD table.
- PRBS7 taps.
- The state enum {HUNT, TRACK}.
REQ-036 ask_pkg is shared with the transmit-side PRBS generator.
REQ-037 Rectifier and peak hold sit in one sub-module, ask_envelope_detector, with outputs envelope and env_level.

Verification
REQ-038 Constant sample 2048 with threshold 512 -> envelope 0, env_level 0, locked 0, and no bit_valid.
REQ-039 Carrier at amplitude 1800 (window >= 1 period), sel=11, keyed 1,0,1,1,0 with off-amplitude 100 and threshold 900:
- locked at the first 0->1 transition.
- bit_valid every 512 samples.
- bits 1,0,1,1,0 appear at mid-bit.
REQ-040 Locked stream, then bit_rate_sel 11->10 mid-bit -> that cycle locked=0 and no strobe; relock on the next transition; strobes then 1024 samples apart.
REQ-041 Locked stream, then constant high level for 33 periods -> locked drops after exactly 32 periods without a transition; no strobes afterwards.
REQ-042 Reset asserted mid-bit for 3 cycles -> all outputs 0 on the following edge; first strobe only after a new transition plus P/2 samples.
REQ-043 With ASK_DEMOD_PRBS_CHECK_EN, a PRBS7 keyed stream with bit 40 inverted:
- prbs_sync = 1 after 23 bits.
- err_count = 1 following bit 40.
- Without the macro, err_count stays 0.
